// File: rtl/riscv_pkg.sv
//==============================================================================
// Module      : riscv_pkg
// Description : Shared types and constants for the load/store unit: FSM state
//               encoding, funct3 access encodings and access-size helpers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package riscv_pkg;

    // LSU control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // funct3 encodings shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size codes derived from funct3[1:0]
    localparam logic [1:0] c_sz_b = 2'b00;
    localparam logic [1:0] c_sz_h = 2'b01;
    localparam logic [1:0] c_sz_w = 2'b10;

    // Reserved size encodings fall back to a full-word access
    function automatic logic [1:0] f3_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return c_sz_b;
            2'b01:   return c_sz_h;
            default: return c_sz_w;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
//==============================================================================
// Module      : lsu_align
// Description : Combinational byte-lane logic. Store side builds byte enables
//               and lane-replicated write data; load side extracts the
//               addressed byte/half from the read word and extends it.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lsu_align (
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_lo,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_lo,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);
    import riscv_pkg::*;

    logic [15:0] w_lane;

    // Store: replicate the datum across all lanes, enable only the target ones
    always_comb begin
        o_be    = 4'hF;
        o_wdata = i_st_data;
        case (i_st_size)
            c_sz_b: begin
                o_be    = 4'b0001 << i_st_lo;
                o_wdata = {4{i_st_data[7:0]}};
            end
            c_sz_h: begin
                o_be    = 4'b0011 << {i_st_lo[1], 1'b0};
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load: shift the addressed lane down to bit 0, then extend per funct3
    always_comb begin
        w_lane = 16'(i_ld_word >> {i_ld_lo, 3'b000});
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
            F3_H:    o_ld_data = {{16{w_lane[15]}}, w_lane};
            F3_BU:   o_ld_data = {24'h0, w_lane[7:0]};
            F3_HU:   o_ld_data = {16'h0, w_lane};
            default: o_ld_data = i_ld_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
//==============================================================================
// Module      : load_store_unit
// Description : Load/store unit between the EX/MEM register and data memory.
//               Accepts one access per handshake, runs req/gnt/rvalid to
//               memory, returns extended load data to writeback, and aborts
//               with lsu_err if memory stalls for WAIT_MAX cycles.
//               Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word
//               accesses are rejected with lsu_err instead of being aligned.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module load_store_unit #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_re,
    input  logic              ex_we,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [4:0]        ex_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              lsu_err
);
    import riscv_pkg::*;

    localparam int                    c_timer_w    = $clog2(WAIT_MAX + 1);
    localparam logic [c_timer_w-1:0]  c_timer_last = c_timer_w'(WAIT_MAX - 1);

    lsu_state_t           r_state;
    logic [c_timer_w-1:0] r_timer;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [3:0]           r_be;
    logic [31:0]          r_wdata;
    logic [2:0]           r_funct3;
    logic [1:0]           r_lo;
    logic [4:0]           r_rd;
    logic [4:0]           r_wb_rd;
    logic [31:0]          r_wb_data;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_is_store;
    logic                 w_trap;
    logic [1:0]           w_size;
    logic [1:0]           w_lo;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic [31:0]          w_ld_data;
    logic                 w_timeout;
    logic                 w_unused;

    // Upper address bits wrap away: memory is only 2^ADDR_W words deep
    assign w_unused   = ^ex_addr[31:ADDR_W+2];

    assign w_accept   = (r_state == IDLE) & ex_valid & (ex_re | ex_we);
    assign w_is_store = ex_we & ~ex_re;
    assign w_size     = f3_size(ex_funct3[1:0]);
    assign w_timeout  = (r_timer == c_timer_last);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = ((w_size == c_sz_h) & ex_addr[0]) |
                    ((w_size == c_sz_w) & (ex_addr[1:0] != 2'b00));
`else
    assign w_trap = 1'b0;
`endif

    // Byte offset forced to natural alignment for the access size
    always_comb begin
        case (w_size)
            c_sz_b:  w_lo = ex_addr[1:0];
            c_sz_h:  w_lo = {ex_addr[1], 1'b0};
            default: w_lo = 2'b00;
        endcase
    end

    lsu_align u_align (
        .i_st_size   (w_size),
        .i_st_lo     (w_lo),
        .i_st_data   (ex_wdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .i_ld_funct3 (r_funct3),
        .i_ld_lo     (r_lo),
        .i_ld_word   (mem_rdata),
        .o_ld_data   (w_ld_data)
    );

    // Control FSM, stall timer and request/response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= 4'h0;
            r_wdata   <= 32'h0;
            r_funct3  <= 3'b000;
            r_lo      <= 2'b00;
            r_rd      <= 5'd0;
            r_wb_rd   <= 5'd0;
            r_wb_data <= 32'h0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_trap) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state  <= REQ;
                            r_timer  <= '0;
                            r_we     <= w_is_store;
                            r_addr   <= ex_addr[ADDR_W+1:2];
                            r_be     <= w_be;
                            r_wdata  <= w_is_store ? w_wdata : 32'h0;
                            r_funct3 <= ex_funct3;
                            r_lo     <= w_lo;
                            r_rd     <= ex_rd;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        r_state <= r_we ? IDLE : WAIT;
                        r_timer <= '0;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                        r_timer <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_timer_w'(1);
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        r_state   <= RESP;
                        r_timer   <= '0;
                        r_wb_rd   <= r_rd;
                        r_wb_data <= w_ld_data;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                        r_timer <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_timer_w'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_timer <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ex_ready  = (r_state == IDLE);
    assign mem_req   = (r_state == REQ);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;
    assign wb_valid  = (r_state == RESP);
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign lsu_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//==============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Expected memory
//               requests and writeback results are queued at issue time from
//               a reference model and popped when the DUT presents them.
//               Honours LSU_MISALIGN_TRAP_EN when defined for the build.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_load_store_unit;

    localparam int ADDR_W   = 10;
    localparam int WAIT_MAX = 255;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       wdata;
    } mem_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid, ex_ready, ex_re, ex_we;
    logic [2:0]        ex_funct3;
    logic [31:0]       ex_addr, ex_wdata;
    logic [4:0]        ex_rd;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt, mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              lsu_err;

    mem_t mem_q[$];
    wb_t  wb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_re      (ex_re),
        .ex_we      (ex_we),
        .ex_funct3  (ex_funct3),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .ex_rd      (ex_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .lsu_err    (lsu_err)
    );

    // ---------------- reference model ----------------
    function automatic logic [1:0] m_lo(input logic [2:0] f3, input logic [31:0] a);
        case (f3[1:0])
            2'b00:   return a[1:0];
            2'b01:   return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic m_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || (f3[1] && (a[1:0] != 2'b00));
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] lo);
        if (f3[1:0] == 2'b00) begin
            case (lo)
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end else if (f3[1:0] == 2'b01) begin
            return lo[1] ? 4'b1100 : 4'b0011;
        end
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic st, input logic [2:0] f3, input logic [31:0] d);
        if (!st) return 32'h0;
        if (f3[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (f3[1:0] == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            LB:      return {{24{b[7]}}, b};
            LH:      return {{16{h[15]}}, h};
            LBU:     return {24'h0, b};
            LHU:     return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    // Presents one request for a cycle; returns in the cycle after acceptance
    task automatic issue(input logic re, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                         input logic [31:0] rdata, output logic issued);
        mem_t m;
        wb_t  w;
        logic st;
        st     = we & ~re;
        issued = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if (m_misaligned(f3, a)) issued = 1'b0;
`endif
        if (issued) begin
            m.we    = st;
            m.addr  = a[ADDR_W+1:2];
            m.be    = m_be(f3, m_lo(f3, a));
            m.wdata = m_wdata(st, f3, d);
            mem_q.push_back(m);
            if (!st) begin
                w.rd   = rd;
                w.data = m_load(f3, m_lo(f3, a), rdata);
                wb_q.push_back(w);
            end
        end
        ex_valid = 1'b1; ex_re = re; ex_we = we; ex_funct3 = f3;
        ex_addr = a; ex_wdata = d; ex_rd = rd;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_re = 1'b0; ex_we = 1'b0;
        ex_addr = $urandom; ex_wdata = $urandom;
    endtask

    // Holds gnt low for dly cycles, counting any change on the request, then grants
    task automatic grant(input int dly, output mem_t obs, output int unstable);
        mem_t s0;
        s0 = '{mem_we, mem_addr, mem_be, mem_wdata};
        unstable = 0;
        for (int i = 0; i < dly; i++) begin
            if (mem_req !== 1'b1 || ex_ready !== 1'b0 ||
                s0 !== mem_t'{mem_we, mem_addr, mem_be, mem_wdata}) unstable++;
            @(posedge clk); #1;
        end
        if (mem_req !== 1'b1) unstable++;
        obs = '{mem_we, mem_addr, mem_be, mem_wdata};
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
    endtask

    // Returns read data after dly cycles; samples writeback one cycle later
    task automatic respond(input int dly, input logic [31:0] rdata,
                           output logic got_v, output wb_t got, output int early);
        early = 0;
        for (int i = 0; i < dly; i++) begin
            if (wb_valid !== 1'b0) early++;
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        got_v = wb_valid;
        got   = '{wb_rd, wb_data};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ex_ready); end
        n_vec++; if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
            n_err++; $display("FAIL reset_mem got %h want 0", {mem_req, mem_we, mem_addr, mem_be, mem_wdata}); end
        n_vec++; if ({wb_valid, wb_rd, wb_data, lsu_err} !== '0) begin
            n_err++; $display("FAIL reset_wb got %h want 0", {wb_valid, wb_rd, wb_data, lsu_err}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        logic iss; mem_t o, e; int u;
        issue(1'b0, 1'b1, LW, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0, iss);
        n_vec++; if (mem_req !== 1'b1 || ex_ready !== 1'b0) begin
            n_err++; $display("FAIL sw_t1 got req=%b rdy=%b want req=1 rdy=0", mem_req, ex_ready); end
        grant(0, o, u);
        e = mem_q.pop_front();
        n_vec++; if (o !== e) begin n_err++; $display("FAIL sw_mem got %h want %h", o, e); end
        n_vec++; if (ex_ready !== 1'b1 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL sw_t2 got rdy=%b req=%b want rdy=1 req=0", ex_ready, mem_req); end
    endtask

    task automatic test_load_byte();
        logic iss, v; mem_t o, e; wb_t g, ew; int u, early;
        issue(1'b1, 1'b0, LB, 32'h13, 32'h0, 5'd9, 32'h80FF_0000, iss);
        grant(0, o, u);
        e = mem_q.pop_front();
        n_vec++; if (o !== e) begin n_err++; $display("FAIL lb_mem got %h want %h", o, e); end
        respond(0, 32'h80FF_0000, v, g, early);
        ew = wb_q.pop_front();
        n_vec++; if (v !== 1'b1 || g !== ew) begin
            n_err++; $display("FAIL lb_wb got v=%b %h want v=1 %h", v, g, ew); end
        @(posedge clk); #1;
        n_vec++; if (wb_valid !== 1'b0 || wb_data !== 32'hFFFF_FF80 || ex_ready !== 1'b1) begin
            n_err++; $display("FAIL lb_after got v=%b d=%h rdy=%b want v=0 d=ffffff80 rdy=1", wb_valid, wb_data, ex_ready); end
        issue(1'b1, 1'b0, LBU, 32'h13, 32'h0, 5'd10, 32'h80FF_0000, iss);
        grant(0, o, u);
        e = mem_q.pop_front();
        respond(0, 32'h80FF_0000, v, g, early);
        ew = wb_q.pop_front();
        n_vec++; if (v !== 1'b1 || g !== ew || g.data !== 32'h0000_0080) begin
            n_err++; $display("FAIL lbu_wb got v=%b %h want v=1 %h", v, g, ew); end
        @(posedge clk); #1;
    endtask

    task automatic test_half();
        logic iss, v; mem_t o, e; wb_t g, ew; int u, early;
        issue(1'b0, 1'b1, LH, 32'h6, 32'h0000_1234, 5'd0, 32'h0, iss);
        grant(0, o, u);
        e = mem_q.pop_front();
        n_vec++; if (o !== e || o.be !== 4'b1100 || o.wdata !== 32'h1234_1234) begin
            n_err++; $display("FAIL sh_mem got %h want %h", o, e); end
        issue(1'b1, 1'b0, LH, 32'h6, 32'h0, 5'd3, 32'hABCD_0000, iss);
        grant(0, o, u);
        e = mem_q.pop_front();
        respond(0, 32'hABCD_0000, v, g, early);
        ew = wb_q.pop_front();
        n_vec++; if (v !== 1'b1 || g !== ew || g.data !== 32'hFFFF_ABCD) begin
            n_err++; $display("FAIL lh_wb got v=%b %h want v=1 %h", v, g, ew); end
        @(posedge clk); #1;
    endtask

    task automatic test_gnt_stall();
        logic iss, v; mem_t o, e; wb_t g, ew; int u, early;
        issue(1'b0, 1'b1, LB, 32'h25, 32'h0000_00A5, 5'd0, 32'h0, iss);
        grant(5, o, u);
        e = mem_q.pop_front();
        n_vec++; if (u != 0) begin n_err++; $display("FAIL stall_stable got %0d changes want 0", u); end
        n_vec++; if (o !== e) begin n_err++; $display("FAIL stall_mem got %h want %h", o, e); end
        issue(1'b1, 1'b0, LHU, 32'h2, 32'h0, 5'd17, 32'h8001_0000, iss);
        grant(3, o, u);
        e = mem_q.pop_front();
        respond(4, 32'h8001_0000, v, g, early);
        ew = wb_q.pop_front();
        n_vec++; if (u != 0 || early != 0 || o !== e) begin
            n_err++; $display("FAIL stall_ld got u=%0d early=%0d %h want 0 0 %h", u, early, o, e); end
        n_vec++; if (v !== 1'b1 || g !== ew) begin
            n_err++; $display("FAIL stall_ld_wb got v=%b %h want v=1 %h", v, g, ew); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_noop();
        ex_valid = 1'b1; ex_re = 1'b0; ex_we = 1'b0; ex_addr = 32'h44;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        n_vec++; if (ex_ready !== 1'b1 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL noop got rdy=%b req=%b want rdy=1 req=0", ex_ready, mem_req); end
    endtask

    task automatic test_misalign();
        logic iss, v; mem_t o, e; wb_t g, ew; int u, early;
        issue(1'b1, 1'b0, LW, 32'h2, 32'h0, 5'd4, 32'h1122_3344, iss);
`ifdef LSU_MISALIGN_TRAP_EN
        n_vec++; if (lsu_err !== 1'b1 || mem_req !== 1'b0 || ex_ready !== 1'b1) begin
            n_err++; $display("FAIL mis_trap got err=%b req=%b rdy=%b want 1 0 1", lsu_err, mem_req, ex_ready); end
        @(posedge clk); #1;
        n_vec++; if (lsu_err !== 1'b0 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin
            n_err++; $display("FAIL mis_after got err=%b req=%b wbv=%b want 0 0 0", lsu_err, mem_req, wb_valid); end
`else
        grant(0, o, u);
        e = mem_q.pop_front();
        n_vec++; if (o !== e || o.addr !== '0 || o.be !== 4'hF) begin
            n_err++; $display("FAIL mis_lw_mem got %h want %h", o, e); end
        respond(0, 32'h1122_3344, v, g, early);
        ew = wb_q.pop_front();
        n_vec++; if (v !== 1'b1 || g !== ew || lsu_err !== 1'b0) begin
            n_err++; $display("FAIL mis_lw_wb got v=%b %h err=%b want v=1 %h err=0", v, g, lsu_err, ew); end
        @(posedge clk); #1;
        issue(1'b0, 1'b1, LH, 32'h7, 32'h0000_BEEF, 5'd0, 32'h0, iss);
        grant(0, o, u);
        e = mem_q.pop_front();
        n_vec++; if (o !== e) begin n_err++; $display("FAIL mis_sh_mem got %h want %h", o, e); end
`endif
    endtask

    task automatic test_timeout();
        logic iss; mem_t o, e; wb_t ew; int u, cnt, wbs;
        issue(1'b1, 1'b0, LW, 32'h20, 32'h0, 5'd6, 32'h0, iss);
        grant(0, o, u);
        e  = mem_q.pop_front();
        ew = wb_q.pop_front();
        cnt = 0; wbs = 0;
        while (lsu_err !== 1'b1 && cnt < 2 * WAIT_MAX + 10) begin
            if (wb_valid !== 1'b0) wbs++;
            @(posedge clk); #1;
            cnt++;
        end
        n_vec++; if (cnt != WAIT_MAX) begin
            n_err++; $display("FAIL tmo_cycles got %0d want %0d", cnt, WAIT_MAX); end
        n_vec++; if (wbs != 0 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            n_err++; $display("FAIL tmo_state got wbv=%0d rdy=%b want 0 1 (dropped rd %0d)", wbs, ex_ready, ew.rd); end
        @(posedge clk); #1;
        n_vec++; if (lsu_err !== 1'b0 || wb_valid !== 1'b0) begin
            n_err++; $display("FAIL tmo_pulse got err=%b wbv=%b want 0 0", lsu_err, wb_valid); end
    endtask

    task automatic test_reset_mid();
        logic iss; mem_t o, e; wb_t ew; int u;
        issue(1'b1, 1'b0, LW, 32'h40, 32'h0, 5'd7, 32'h0, iss);
        grant(0, o, u);
        e  = mem_q.pop_front();
        ew = wb_q.pop_front();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (ex_ready !== 1'b1 || {mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
            n_err++; $display("FAIL rstmid_mem got rdy=%b %h want rdy=1 0", ex_ready, {mem_req, mem_we, mem_addr, mem_be, mem_wdata}); end
        n_vec++; if ({wb_valid, wb_rd, wb_data, lsu_err} !== '0) begin
            n_err++; $display("FAIL rstmid_wb got %h want 0", {wb_valid, wb_rd, wb_data, lsu_err}); end
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        n_vec++; if (wb_valid !== 1'b0 || wb_data !== 32'h0 || ex_ready !== 1'b1) begin
            n_err++; $display("FAIL rstmid_rvalid got v=%b d=%h rdy=%b want 0 0 1 (dropped rd %0d)", wb_valid, wb_data, ex_ready, ew.rd); end
    endtask

    task automatic test_back_to_back();
        logic iss, v, ld; mem_t o, e; wb_t g, ew; int u, early;
        logic [2:0] f3; logic [31:0] a, rd_w;
        logic [2:0] ld_f3s [5];
        ld_f3s = '{LB, LH, LW, LBU, LHU};
        for (int k = 0; k < 24; k++) begin
            ld   = $urandom_range(0, 1);
            f3   = ld ? ld_f3s[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            a    = $urandom;
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1]) a[1:0] = 2'b00;
            rd_w = $urandom;
            issue(ld, ld ? 1'($urandom_range(0, 1)) : 1'b1, f3, a, $urandom,
                  5'($urandom_range(1, 31)), rd_w, iss);
            grant($urandom_range(0, 3), o, u);
            e = mem_q.pop_front();
            n_vec++; if (o !== e || u != 0) begin
                n_err++; $display("FAIL b2b_mem[%0d] got %h u=%0d want %h", k, o, u, e); end
            if (ld) begin
                respond($urandom_range(0, 3), rd_w, v, g, early);
                ew = wb_q.pop_front();
                n_vec++; if (v !== 1'b1 || g !== ew || early != 0) begin
                    n_err++; $display("FAIL b2b_wb[%0d] got v=%b %h early=%0d want v=1 %h", k, v, g, early, ew); end
                @(posedge clk); #1;
            end
        end
    endtask

    // Hard stop in case a wait never resolves
    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_re = 1'b0; ex_we = 1'b0; ex_funct3 = 3'b000;
        ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_store_word();
        test_load_byte();
        test_half();
        test_gnt_stall();
        test_ignore_noop();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
